// File: rtl/uart_frame_parser.sv
// uart_frame_parser: sync/length/XOR-checked frame decoder behind a UART RX.
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 52080,
  localparam int        AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  input  logic          i_Frame_Ack,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic          o_Frame_Valid,
  output logic [7:0]    o_Frame_Cmd,
  output logic [7:0]    o_Frame_Len,
  output logic [7:0]    o_Rd_Data,
  output logic          o_Err,
  output logic [1:0]    o_Err_Code,
  output logic          o_Drop
);

  localparam int         CW    = $clog2(MAX_LEN + 1);
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] MAX8  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT, S_CMD, S_LEN, S_PAY, S_CHK, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, len_q, chk_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    mem [DEPTH];
  logic          err_q, err_d, drop_q, drop_d;
  logic [1:0]    code_q, code_d;
  logic          wr_en, last_pay, tmo;

  assign last_pay = (8'(cnt_q) + 8'd1) == len_q;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] idle_q;
  logic          in_frame;

  assign in_frame = (state_q == S_CMD) || (state_q == S_LEN) ||
                    (state_q == S_PAY) || (state_q == S_CHK);
  assign tmo = in_frame && !i_RX_DV &&
               (idle_q == TW'(TIMEOUT_CLKS - 1));

  // idle clocks since the last byte while a frame is in progress
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L)
      idle_q <= '0;
    else if (!in_frame || i_RX_DV || tmo)
      idle_q <= '0;
    else
      idle_q <= idle_q + TW'(1);
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CLKS < 2);
  assign tmo = 1'b0;
`endif

  // next state, error/drop pulses and payload write enable
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = 2'b00;
    drop_d  = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_HUNT:
        if (i_RX_DV && i_RX_Byte == SYNC_BYTE)
          state_d = S_CMD;
      S_CMD:
        if (i_RX_DV)
          state_d = S_LEN;
      S_LEN:
        if (i_RX_DV) begin
          if (i_RX_Byte > MAX8) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_HUNT;
          end else if (i_RX_Byte == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAY;
          end
        end
      S_PAY:
        if (i_RX_DV) begin
          wr_en = 1'b1;
          if (last_pay)
            state_d = S_CHK;
        end
      S_CHK:
        if (i_RX_DV) begin
          if (i_RX_Byte == chk_q) begin
            state_d = S_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'b10;
            state_d = S_HUNT;
          end
        end
      S_HOLD: begin
        drop_d = i_RX_DV;
        if (i_Frame_Ack)
          state_d = S_HUNT;
      end
      default:
        state_d = S_HUNT;
    endcase
    if (tmo) begin
      err_d   = 1'b1;
      code_d  = 2'b11;
      state_d = S_HUNT;
    end
  end

  // state register
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L)
      state_q <= S_HUNT;
    else
      state_q <= state_d;
  end

  // header capture, running checksum, byte counter and output pulses
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      cmd_q  <= '0;
      len_q  <= '0;
      chk_q  <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
      code_q <= 2'b00;
      drop_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      code_q <= code_d;
      drop_q <= drop_d;
      rd_q   <= mem[i_Rd_Addr];
      if (i_RX_DV) begin
        unique case (state_q)
          S_CMD: begin
            cmd_q <= i_RX_Byte;
            chk_q <= i_RX_Byte;
          end
          S_LEN: begin
            len_q <= i_RX_Byte;
            chk_q <= chk_q ^ i_RX_Byte;
            cnt_q <= '0;
          end
          S_PAY: begin
            chk_q <= chk_q ^ i_RX_Byte;
            cnt_q <= cnt_q + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // payload buffer, never cleared by reset
  always_ff @(posedge i_Clock) begin
    if (i_Rst_L && wr_en)
      mem[cnt_q[AW-1:0]] <= i_RX_Byte;
  end

  assign o_Frame_Valid = (state_q == S_HOLD);
  assign o_Frame_Cmd   = cmd_q;
  assign o_Frame_Len   = len_q;
  assign o_Rd_Data     = rd_q;
  assign o_Err         = err_q;
  assign o_Err_Code    = code_q;
  assign o_Drop        = drop_q;

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-to-frame decoder sitting directly downstream of the UART receiver. It consumes the receiver's one-cycle byte-valid strobe and data byte, hunts for a sync byte, checks length and XOR checksum, and buffers one validated frame payload for a downstream command handler. The buffered frame is held until acknowledged. Errors are reported as single-cycle pulses with a cause code.

## Interface
- MAX_LEN, 16: maximum payload bytes accepted, 1..255; sets buffer depth.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CLKS, 52080: inter-byte timeout in clocks, ≥2. Used only with FRAME_TIMEOUT_EN.
- i_Clock  input  1: single clock for the whole block.
- i_Rst_L  input  1: reset, synchronous and active-low.
- i_RX_DV  input  1: one-cycle strobe, byte valid, from the UART receiver.
- i_RX_Byte  input  8: received byte, valid when i_RX_DV=1.
- i_Frame_Ack  input  1: downstream has consumed the held frame.
- i_Rd_Addr  input  $clog2(MAX_LEN): payload read address.
- o_Frame_Valid  output  1: level; a validated frame is held.
- o_Frame_Cmd  output  8: CMD byte of the held frame.
- o_Frame_Len  output  8: LEN byte of the held frame.
- o_Rd_Data  output  8: payload byte at i_Rd_Addr, registered.
- o_Err  output  1: one-cycle error pulse.
- o_Err_Code  output  2: cause, valid with o_Err: 01 = length > MAX_LEN, 10 = checksum mismatch, 11 = timeout.
- o_Drop  output  1: one-cycle pulse; a byte was discarded while in HOLD.

## Operation
- Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.
- State HUNT:
  - i_RX_DV with byte == SYNC_BYTE -> CMD.
  - Any other byte is ignored silently.
- State CMD: on i_RX_DV, store the byte, seed the checksum with it -> LEN.
- State LEN: on i_RX_DV, XOR the byte into the checksum.
  - LEN > MAX_LEN -> o_Err with code 01 -> HUNT.
  - LEN == 0 -> CHK.
  - Otherwise -> PAYLOAD, with the byte counter cleared.
- State PAYLOAD: on each i_RX_DV, write buffer[counter], XOR into the checksum, increment the counter. After the LEN-th byte -> CHK.
- State CHK: on i_RX_DV, compare the byte with the checksum.
  - Match -> HOLD, o_Frame_Valid=1.
  - Mismatch -> o_Err with code 10 -> HUNT.
- State HOLD:
  - o_Frame_Cmd, o_Frame_Len and the buffer are frozen.
  - Every i_RX_DV is discarded with an o_Drop pulse.
  - i_Frame_Ack=1 -> clear o_Frame_Valid -> HUNT.
- A SYNC_BYTE value received inside CMD, LEN, PAYLOAD or CHK is data. There is no resync mid-frame.
- Payload and checksum arithmetic is 8-bit XOR only; the counter is $clog2(MAX_LEN+1) bits and never wraps.
- o_Rd_Data reads the buffer at any time. Contents are meaningful only for addresses < o_Frame_Len while o_Frame_Valid=1.

## Timing
- Reset (i_Rst_L=0 at the clock edge):
  - State -> HUNT.
  - o_Frame_Valid, o_Err, o_Drop = 0.
  - o_Err_Code, o_Frame_Cmd, o_Frame_Len, o_Rd_Data = 0.
  - Buffer contents are not cleared.
  - Reset mid-frame or in HOLD discards the frame with no error pulse.
- o_Frame_Valid rises the cycle after the clock edge that samples the CHK byte.
- o_Err rises the cycle after the clock edge that samples the offending byte, or after the timeout expiry edge.
- o_Rd_Data has 1-cycle latency: the address sampled at edge N gives data valid after edge N.
- i_Frame_Ack is ignored outside HOLD. In HOLD, o_Frame_Valid falls the cycle after the ack is sampled.
- Ack and i_RX_DV in the same HOLD cycle: the ack is taken, the byte is dropped with o_Drop.
- Bytes arrive ≥1 cycle apart. A new byte may be accepted in HUNT the cycle after the ack.

## Configuration
- FRAME_TIMEOUT_EN defined:
  - An idle counter runs in CMD, LEN, PAYLOAD and CHK, and is cleared on every i_RX_DV.
  - On reaching TIMEOUT_CLKS-1 with no i_RX_DV: o_Err with code 11 -> HUNT.
  - i_RX_DV in the expiry cycle wins; there is no timeout.
  - The counter is held at 0 in HUNT and HOLD.
- FRAME_TIMEOUT_EN undefined: no counter logic; a partial frame waits indefinitely; code 11 is never produced.

## Test plan
- Good frame A5 10 02 33 44 65 -> o_Frame_Valid=1, Cmd=10, Len=02, Rd addr0=33, addr1=44. Ack -> Valid=0 next cycle.
- Bad checksum A5 10 02 33 44 66 -> o_Err pulse, code 10, Valid stays 0. Following good frame is accepted.
- Length error A5 01 11 with MAX_LEN=16 -> o_Err code 01 after the LEN byte. Parser resyncs on the next A5.
- Zero-length frame A5 7E 00 7E -> Valid=1, Len=00. Then 3 bytes sent while holding -> 3 o_Drop pulses; ack together with a 4th byte -> Drop plus Valid falls.
- With FRAME_TIMEOUT_EN and TIMEOUT_CLKS=20: A5 10 then idle 20 clocks -> o_Err code 11. A byte arriving exactly at expiry -> no error.
- Assert i_Rst_L=0 mid-payload -> all outputs 0, no o_Err. A complete good frame after release is accepted.
